// File: rtl/can_bit_timing.sv
// can_bit_timing
//   Bit-timing and sampling front end for the CAN receive path. Synchronises
//   the raw bus level, divides the system clock into time quanta, hard-syncs
//   on start of frame and resynchronises on later recessive-to-dominant edges.
//
// Ports
//   clock       system clock
//   reset       asynchronous, active-high reset
//   enable      1 = timing active; 0 = counters held at reset values
//   can_rx_pin  raw asynchronous bus level (1 = recessive)
//   R_frame     one-clock pulse at each sample point
//   Can_rx      sampled bit, updated in the R_frame cycle
//   bus_idle    IDLE_BITS consecutive recessive samples seen
//   resync_evt  one-clock pulse when a hard sync or resync is applied
module can_bit_timing #(
  parameter int unsigned PRESCALER = 10,
  parameter int unsigned TSEG1     = 13,
  parameter int unsigned TSEG2     = 2,
  parameter int unsigned SJW       = 1,
  parameter int unsigned IDLE_BITS = 11
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic can_rx_pin,
  output logic R_frame,
  output logic Can_rx,
  output logic bus_idle,
  output logic resync_evt
);

  localparam int unsigned NBT = 1 + TSEG1 + TSEG2;
  localparam int unsigned PW  = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam int unsigned TW  = $clog2(NBT + SJW);
  localparam int unsigned EW  = $clog2(SJW + 1);
  localparam int unsigned IW  = $clog2(IDLE_BITS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALER - 1);
  localparam logic [TW-1:0] TSEG1_TQ   = TW'(TSEG1);
  localparam logic [TW-1:0] LAST_TQ    = TW'(NBT - 1);
  localparam logic [TW-1:0] SJW_TQ     = TW'(SJW);
  localparam logic [TW:0]   NBT_W      = (TW + 1)'(NBT);
  localparam logic [EW-1:0] SJW_E      = EW'(SJW);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_BITS);

  typedef enum logic [2:0] {
    EDGE_NONE,
    EDGE_HARD,
    EDGE_SYNC_SEG,
    EDGE_POS,
    EDGE_NEG_RESTART,
    EDGE_NEG_SHORTEN
  } edge_t;

  logic          sync1, sync2, sync3;
  logic [PW-1:0] presc, presc_n;
  logic [TW-1:0] tq, tq_n;
  logic [EW-1:0] ext, ext_n;
  logic          edge_done, edge_done_n;
  logic [IW-1:0] idle_cnt, idle_cnt_n;
  logic          can_rx_n, bus_idle_n;

  edge_t         edge_kind;
  logic          fall, tick, sample, bit_end;
  logic [TW-1:0] ext_tq, sample_tq, end_tq, pos;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= can_rx_pin;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_comb begin
    fall      = sync3 & ~sync2;
    ext_tq    = TW'(ext);
    sample_tq = TSEG1_TQ + ext_tq;
    end_tq    = LAST_TQ + ext_tq;
    tick      = enable && (presc == PRESC_LAST);
    sample    = tick && (tq == sample_tq);
    bit_end   = tick && (tq == end_tq);

    // Edges coinciding with a tq tick are classified at the post-tick
    // position: an edge on the sample tick lands past the sample point
    // (negative error) and an edge on the bit-end tick lands in SYNC_SEG.
    if (bit_end)   pos = '0;
    else if (tick) pos = tq + TW'(1);
    else           pos = tq;

    edge_kind = EDGE_NONE;
    if (enable && fall) begin
      if (bus_idle) begin
        edge_kind = EDGE_HARD;
      end else if (!edge_done && Can_rx) begin
        if (pos == '0)
          edge_kind = EDGE_SYNC_SEG;
        else if (pos <= sample_tq)
          edge_kind = EDGE_POS;
        else if (({1'b0, pos} + {1'b0, SJW_TQ}) >= (NBT_W + {1'b0, ext_tq}))
          edge_kind = EDGE_NEG_RESTART;
        else
          edge_kind = EDGE_NEG_SHORTEN;
      end
    end

    presc_n     = tick ? '0 : presc + PW'(1);
    tq_n        = tq;
    ext_n       = ext;
    edge_done_n = edge_done;
    if (tick) begin
      if (bit_end) begin
        tq_n        = '0;
        ext_n       = '0;
        edge_done_n = 1'b0;
      end else begin
        tq_n = tq + TW'(1);
      end
    end

    case (edge_kind)
      EDGE_HARD, EDGE_NEG_RESTART: begin
        presc_n     = '0;
        tq_n        = '0;
        ext_n       = '0;
        edge_done_n = 1'b1;
      end
      EDGE_SYNC_SEG: edge_done_n = 1'b1;
      EDGE_POS: begin
        ext_n       = (pos < SJW_TQ) ? pos[EW-1:0] : SJW_E;
        edge_done_n = 1'b1;
      end
      EDGE_NEG_SHORTEN: begin
        tq_n        = pos + SJW_TQ;
        edge_done_n = 1'b1;
      end
      default: ;
    endcase

    can_rx_n   = sample ? sync2 : Can_rx;
    idle_cnt_n = idle_cnt;
    bus_idle_n = bus_idle;
    if (sample) begin
      if (sync2) begin
        if (idle_cnt != IDLE_MAX) idle_cnt_n = idle_cnt + IW'(1);
        if (idle_cnt_n == IDLE_MAX) bus_idle_n = 1'b1;
      end else begin
        idle_cnt_n = '0;
        bus_idle_n = 1'b0;
      end
    end
    if (edge_kind == EDGE_HARD) bus_idle_n = 1'b0;

    if (!enable) begin
      presc_n     = '0;
      tq_n        = '0;
      ext_n       = '0;
      edge_done_n = 1'b0;
      idle_cnt_n  = '0;
      bus_idle_n  = 1'b1;
    end

    R_frame    = sample;
    resync_evt = (edge_kind == EDGE_HARD) || (edge_kind == EDGE_POS) ||
                 (edge_kind == EDGE_NEG_RESTART) || (edge_kind == EDGE_NEG_SHORTEN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      tq        <= '0;
      ext       <= '0;
      edge_done <= 1'b0;
      idle_cnt  <= '0;
      Can_rx    <= 1'b1;
      bus_idle  <= 1'b1;
    end else begin
      presc     <= presc_n;
      tq        <= tq_n;
      ext       <= ext_n;
      edge_done <= edge_done_n;
      idle_cnt  <= idle_cnt_n;
      Can_rx    <= can_rx_n;
      bus_idle  <= bus_idle_n;
    end
  end

endmodule

// File: tb/tb_can_bit_timing.sv
// tb_can_bit_timing
//   Scoreboard bench for can_bit_timing with default parameters (160-clock
//   nominal bit, sample 140 clocks into the bit). Expected sample pulses and
//   resync pulses are queued as stimulus is applied and checked as they occur.
module tb_can_bit_timing;

  localparam int unsigned IDLE_BITS = 11;

  logic clock = 1'b0;
  logic reset, enable, can_rx_pin;
  logic R_frame, Can_rx, bus_idle, resync_evt;

  int unsigned cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_failed = 0;

  typedef struct {
    int unsigned cyc;
    logic        bit_v;
    logic        idle;
  } rf_exp_t;

  rf_exp_t     exp_rf[$];
  int unsigned exp_rs[$];

  int unsigned idle_run = 0;
  logic        idle_m = 1'b1;

  can_bit_timing #(
    .PRESCALER(10),
    .TSEG1    (13),
    .TSEG2    (2),
    .SJW      (1),
    .IDLE_BITS(IDLE_BITS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .can_rx_pin(can_rx_pin),
    .R_frame   (R_frame),
    .Can_rx    (Can_rx),
    .bus_idle  (bus_idle),
    .resync_evt(resync_evt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    n_tests++;
    if (observed !== expected) begin
      n_failed++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Expected sample: cycle of the R_frame pulse and the bit value; the idle
  // flag expected after that sample follows from the recessive run length.
  task automatic push_rf(input int unsigned c, input logic b);
    rf_exp_t e;
    if (b) begin
      if (idle_run < IDLE_BITS) idle_run++;
      if (idle_run == IDLE_BITS) idle_m = 1'b1;
    end else begin
      idle_run = 0;
      idle_m   = 1'b0;
    end
    e.cyc   = c;
    e.bit_v = b;
    e.idle  = idle_m;
    exp_rf.push_back(e);
  endtask

  task automatic push_rs(input int unsigned c, input logic hard);
    if (hard) idle_m = 1'b0;
    exp_rs.push_back(c);
  endtask

  task automatic goto(input int unsigned k);
    while (cyc < k) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Pin driven just after edge c: edge detect cycle is c+2.
  task automatic fall_at(input int unsigned c, output int unsigned e);
    goto(c);
    can_rx_pin = 1'b0;
    e = c + 2;
  endtask

  task automatic rise_at(input int unsigned c);
    goto(c);
    can_rx_pin = 1'b1;
  endtask

  initial begin : monitor
    rf_exp_t pe;
    logic    pend;
    pend = 1'b0;
    forever begin
      @(negedge clock);
      if (pend) begin
        check_eq("can_rx", Can_rx, pe.bit_v);
        check_eq("bus_idle", bus_idle, pe.idle);
        pend = 1'b0;
      end
      if (resync_evt) begin
        if (exp_rs.size() != 0) check_eq("resync_cyc", cyc, exp_rs.pop_front());
        else                    check_eq("resync_cyc", cyc, 32'hFFFF_FFFF);
      end
      if (R_frame) begin
        if (exp_rf.size() != 0) begin
          pe = exp_rf.pop_front();
          check_eq("rframe_cyc", cyc, pe.cyc);
          pend = 1'b1;
        end else begin
          check_eq("rframe_cyc", cyc, 32'hFFFF_FFFF);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned r0, b, s, e, n_rf, n_rs, n_busy;
    reset      = 1'b1;
    enable     = 1'b1;
    can_rx_pin = 1'b1;
    goto(2);
    check_eq("rst_can_rx", Can_rx, 1);
    check_eq("rst_bus_idle", bus_idle, 1);
    check_eq("rst_rframe", R_frame, 0);
    check_eq("rst_resync", resync_evt, 0);

    // Free-running while idle, then hard sync.
    goto(3);
    reset = 1'b0;
    r0 = 3;
    push_rf(r0 + 139, 1'b1);
    push_rf(r0 + 299, 1'b1);
    fall_at(r0 + 350, e);
    push_rs(e, 1'b1);
    b = e + 1;
    push_rf(b + 139, 1'b0);
    rise_at(b + 145);
    push_rf(b + 299, 1'b1);

    // Bit 3: edge at tq 3 -> bit stretched by one tq.
    s = b + 320;
    fall_at(s + 33, e);
    push_rs(e, 1'b0);
    push_rf(s + 149, 1'b0);
    rise_at(s + 155);
    s = s + 170;
    push_rf(s + 139, 1'b1);

    // Bit 5: edge at tq 15 -> bit restarts.
    s = s + 160;
    push_rf(s + 139, 1'b1);
    fall_at(s + 153, e);
    push_rs(e, 1'b0);
    s = e + 1;
    push_rf(s + 139, 1'b0);
    rise_at(s + 145);

    // Bit 8: edge at tq 14 -> bit shortened to 150 clocks.
    s = s + 160;
    push_rf(s + 139, 1'b1);
    s = s + 160;
    push_rf(s + 139, 1'b1);
    fall_at(s + 143, e);
    push_rs(e, 1'b0);
    s = s + 150;
    push_rf(s + 139, 1'b0);
    rise_at(s + 145);

    // Bit 11: two falling edges, only the first one adjusts.
    s = s + 160;
    push_rf(s + 139, 1'b1);
    s = s + 160;
    fall_at(s + 23, e);
    push_rs(e, 1'b0);
    rise_at(s + 40);
    fall_at(s + 60, e);
    push_rf(s + 149, 1'b0);
    rise_at(s + 155);

    // Reset asserted where the next sample pulse would fall.
    s = s + 170;
    goto(s + 139);
    #1;
    reset = 1'b1;
    #1;
    check_eq("midrst_rframe", R_frame, 0);
    check_eq("midrst_can_rx", Can_rx, 1);
    check_eq("midrst_bus_idle", bus_idle, 1);
    check_eq("midrst_resync", resync_evt, 0);
    idle_run = 0;
    idle_m   = 1'b1;

    // Hard sync, one dominant bit, then a run of recessive bits to idle.
    goto(s + 142);
    reset = 1'b0;
    r0 = s + 142;
    push_rf(r0 + 139, 1'b1);
    fall_at(r0 + 200, e);
    push_rs(e, 1'b1);
    b = e + 1;
    push_rf(b + 139, 1'b0);
    rise_at(b + 145);
    for (int unsigned k = 1; k <= IDLE_BITS; k++) push_rf(b + 139 + 160 * k, 1'b1);

    // Disabled window with a falling edge on the pin.
    goto(b + 1905);
    enable = 1'b0;
    n_rf   = 0;
    n_rs   = 0;
    n_busy = 0;
    for (int unsigned k = 0; k < 400; k++) begin
      @(negedge clock);
      if (k == 100) can_rx_pin = 1'b0;
      if (k == 200) can_rx_pin = 1'b1;
      if (R_frame) n_rf++;
      if (resync_evt) n_rs++;
      if (!bus_idle) n_busy++;
    end
    check_eq("en0_rframe", n_rf, 0);
    check_eq("en0_resync", n_rs, 0);
    check_eq("en0_not_idle", n_busy, 0);
    idle_run = 0;
    idle_m   = 1'b1;

    // Re-enable: free-running from reset values, then a fresh hard sync.
    @(posedge clock);
    #1;
    r0 = cyc;
    enable = 1'b1;
    push_rf(r0 + 139, 1'b1);
    fall_at(r0 + 200, e);
    push_rs(e, 1'b1);
    push_rf(e + 140, 1'b0);
    rise_at(e + 150);
    goto(e + 170);

    check_eq("sb_rf_left", exp_rf.size(), 0);
    check_eq("sb_rs_left", exp_rs.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/can_bit_timing.md
Name: can_bit_timing

Overview:
- Bit-timing and sampling front end for the CAN receive path. It sits directly upstream of the CAN frame receiver.
- Synchronises the raw asynchronous bus input and divides the system clock into time quanta (tq). It tracks bit segments, hard-syncs on start of frame, and resynchronises on later recessive-to-dominant edges.
- Outputs: a one-clock sample tick (R_frame) and the sampled bit (Can_rx), which the frame receiver consumes.

Parameters:
- PRESCALER, 10: system clocks per time quantum (≥1).
- TSEG1, 13: tq from end of SYNC_SEG to sample point (≥2).
- TSEG2, 2: tq from sample point to bit end (≥SJW).
- SJW, 1: resynchronisation jump width in tq (1..4, ≤TSEG1).
- IDLE_BITS, 11: consecutive recessive samples that declare the bus idle.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = timing active; 0 = counters held at reset values.
- can_rx_pin  input  1  raw asynchronous bus level (1 = recessive).
- R_frame  output  1  one-clock pulse at each sample point.
- Can_rx  output  1  sampled bit, updated in the R_frame cycle.
- bus_idle  output  1  bus idle (IDLE_BITS recessive samples seen).
- resync_evt  output  1  one-clock pulse when a hard sync or resync is applied (debug).

Behaviour:
- NBT = 1 + TSEG1 + TSEG2 tq per nominal bit. The tq counter is wide enough for 0..NBT-1+SJW.
- Reset values:
  - Sync flops = 1; Can_rx = 1; bus_idle = 1; R_frame = 0; resync_evt = 0.
  - Prescaler = 0; tq_count = 0; ext = 0; edge_done = 0; idle counter = 0.
- Input path:
  - 2-flop synchroniser, then a third register for edge detect.
  - Falling edge = previous synced value 1 and current 0. Edge-detect cycle E is 2–3 clocks after the pin falls.
- Time quantum:
  - Prescaler counts 0..PRESCALER-1.
  - tq tick = the cycle with prescaler == PRESCALER-1. On a tick, tq_count advances.
- Sample point:
  - Occurs on the tq tick with tq_count == TSEG1 + ext.
  - That cycle: R_frame = 1, and Can_rx <= synced value.
- Bit end:
  - Occurs on the tq tick with tq_count == NBT-1+ext.
  - Then tq_count <= 0, ext <= 0, edge_done <= 0.
- Hard sync (falling edge while bus_idle = 1):
  - In cycle E: prescaler <= 0, tq_count <= 0, ext <= 0, edge_done <= 1, bus_idle <= 0, resync_evt = 1.
  - Resulting first R_frame is at E + TSEG1*PRESCALER + PRESCALER.
- Resynchronisation (falling edge while bus_idle = 0, edge_done = 0 and last Can_rx = 1); otherwise the edge is ignored:
  - tq_count == 0 (SYNC_SEG): no adjustment; edge_done <= 1.
  - 1 ≤ tq_count ≤ TSEG1+ext, before the sample tick: positive error; ext <= min(tq_count, SJW); edge_done <= 1; resync_evt.
  - tq_count > TSEG1+ext: negative error e = NBT+ext-tq_count.
    - If e ≤ SJW: act as hard sync (prescaler <= 0, tq_count <= 0, ext <= 0), but bus_idle is unchanged.
    - Else: tq_count <= tq_count + SJW (bit shortened by SJW tq).
    - In both cases edge_done <= 1 and resync_evt pulses.
- Simultaneous events:
  - An edge in the same cycle as the sample tick: the sample is taken first with the pre-edge position, and the edge is classified as negative error.
  - An edge in the same cycle as bit end: treated as tq_count == 0 (no adjustment).
- Idle detection:
  - Each recessive sample increments the idle counter, saturating at IDLE_BITS. Reaching IDLE_BITS sets bus_idle = 1.
  - A dominant sample clears the counter and bus_idle.
- enable = 0:
  - Synchroniser keeps running.
  - Prescaler, tq_count, ext, edge_done and idle counter are held at reset values; bus_idle = 1; R_frame = 0.
  - On re-enable, a fresh hard sync is required.
- Reset mid-bit: all state returns to reset values immediately, and no R_frame pulse is emitted.

Test Plan:
- Reset release, pin held 1, enable = 1 → bus_idle = 1 and Can_rx = 1; R_frame still pulses every 160 clocks (free-running), resync_evt = 0.
- Pin falls while idle (defaults) → resync_evt at E; R_frame at E+140 with Can_rx = 0; bus_idle = 0; subsequent R_frame every 160 clocks.
- After a recessive sample, dominant edge detected at tq_count = 3 → ext = 1; that bit's R_frame is 170 clocks after the previous one, and the bit is 170 clocks long.
- Edge at tq_count = 15 (e = 1 ≤ SJW) → bit restarts; next R_frame at E+140.
- Edge at tq_count = 14 (e = 2 > SJW) → tq_count jumps to 15; the bit is 150 clocks long.
- Two falling edges in one bit → only the first adjusts timing and resync_evt pulses once.
- 11 consecutive recessive samples → bus_idle = 1 at the 11th R_frame.
- Reset asserted mid-bit → outputs return to reset values in the same cycle.
- enable = 0 → R_frame stays 0.
